// File: rtl/switch_debounce_if.sv
// Switch-side bundle for the debouncer: raw levels in, clean levels and edge pulses out.
interface switch_debounce_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] switch_db;
    logic [WIDTH-1:0] switch_rise;
    logic [WIDTH-1:0] switch_fall;
    logic             switch_changed;

    modport master (
        output switch,
        input  switch_db,
        input  switch_rise,
        input  switch_fall,
        input  switch_changed
    );

    modport slave (
        input  switch,
        output switch_db,
        output switch_rise,
        output switch_fall,
        output switch_changed
    );
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for the board switches,
// with registered rise/fall/any-change pulses aligned to the debounced level update.
module switch_debounce #(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = 120000
) (
    input logic             clk,
    input logic             rst,
    switch_debounce_if.slave bus
);
    localparam int              CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] accept;
    logic             changed;
    logic [CNT_W-1:0] cnt [WIDTH];

    // A bit is accepted on the edge its mismatch has persisted a full window.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= bus.switch;
            sync2   <= sync1;
            db      <= db ^ accept;
            rise    <= accept & sync2;
            fall    <= accept & ~sync2;
            changed <= |accept;
            // Any return to the current level restarts the window from zero.
            for (int i = 0; i < WIDTH; i++) begin
                if ((sync2[i] == db[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.switch_db      = db;
    assign bus.switch_rise    = rise;
    assign bus.switch_fall    = fall;
    assign bus.switch_changed = changed;
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a queue-based scoreboard: stimulus pushes
// the expected accept events, a negedge monitor pops them when switch_changed fires.
module tb_switch_debounce;
    localparam int WIDTH         = 3;
    localparam int STABLE_CYCLES = 4;
    localparam int LATENCY       = STABLE_CYCLES + 2;

    typedef struct {
        int             cyc;
        logic [WIDTH-1:0] db;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [WIDTH-1:0] prev_db = '0;

    switch_debounce_if #(.WIDTH(WIDTH)) bus ();

    switch_debounce #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    // Drives a switch value just after a negedge, optionally queues the accept event
    // it must cause LATENCY edges later, then holds for the given number of cycles.
    task automatic applyStimulus(input logic [WIDTH-1:0] value, input int hold, input bit has_exp,
                                 input logic [WIDTH-1:0] e_db, input logic [WIDTH-1:0] e_rise,
                                 input logic [WIDTH-1:0] e_fall);
        exp_t e;
        bus.switch = value;
        if (has_exp) begin
            e.cyc  = cyc + LATENCY;
            e.db   = e_db;
            e.rise = e_rise;
            e.fall = e_fall;
            exp_q.push_back(e);
        end
        repeat (hold) @(negedge clk);
        #1;
    endtask

    // Monitor: every change event must match the head of the queue at the right cycle;
    // between events the clean level must hold and no pulse may appear.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            checkOutput("reset_hold_outputs",
                        {bus.switch_db, bus.switch_rise, bus.switch_fall, bus.switch_changed}, '0);
            prev_db = '0;
        end else if (rst === 1'b0) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                e = exp_q.pop_front();
                checkOutput("missed_event_cycle", cyc, e.cyc);
            end
            if (bus.switch_changed === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_change", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_cycle", cyc, e.cyc);
                    checkOutput("event_db", bus.switch_db, e.db);
                    checkOutput("event_rise", bus.switch_rise, e.rise);
                    checkOutput("event_fall", bus.switch_fall, e.fall);
                end
            end else begin
                checkOutput("quiet_cycle", {bus.switch_db, bus.switch_rise, bus.switch_fall},
                            {prev_db, {WIDTH{1'b0}}, {WIDTH{1'b0}}});
            end
            prev_db = bus.switch_db;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bus.switch = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_db", bus.switch_db, 3'b000);
        checkOutput("reset_rise", bus.switch_rise, 3'b000);
        checkOutput("reset_fall", bus.switch_fall, 3'b000);
        checkOutput("reset_changed", bus.switch_changed, 1'b0);
        rst = 1'b0;
        applyStimulus(3'b000, 2, 1'b0, '0, '0, '0);

        $display("[TB] clean rise");
        applyStimulus(3'b001, 10, 1'b1, 3'b001, 3'b001, 3'b000);

        $display("[TB] short glitch then minimum accepted pulse");
        applyStimulus(3'b011, 3, 1'b0, '0, '0, '0);
        applyStimulus(3'b001, 8, 1'b0, '0, '0, '0);
        applyStimulus(3'b011, 4, 1'b1, 3'b011, 3'b010, 3'b000);
        applyStimulus(3'b001, 10, 1'b1, 3'b001, 3'b000, 3'b010);

        $display("[TB] bounce train");
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 3'b101 : 3'b001, 2, 1'b0, '0, '0, '0);
        end
        applyStimulus(3'b101, 10, 1'b1, 3'b101, 3'b100, 3'b000);

        $display("[TB] return to zero, then simultaneous rise");
        applyStimulus(3'b000, 10, 1'b1, 3'b000, 3'b000, 3'b101);
        applyStimulus(3'b111, 10, 1'b1, 3'b111, 3'b111, 3'b000);

        $display("[TB] fall of bit 1");
        applyStimulus(3'b101, 10, 1'b1, 3'b101, 3'b000, 3'b010);

        $display("[TB] mid-count reset");
        applyStimulus(3'b011, 3, 1'b0, '0, '0, '0);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_clear",
                    {bus.switch_db, bus.switch_rise, bus.switch_fall, bus.switch_changed}, '0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(3'b011, 10, 1'b1, 3'b011, 3'b011, 3'b000);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
